// File: rtl/serial_pkg.sv
// Shared definitions for the serial IP: CONTROL field encodings, the receive
// FSM state type and the default oversampling ratio.
package serial_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [1:0] {
        SIZE_5 = 2'b00,
        SIZE_6 = 2'b01,
        SIZE_7 = 2'b10,
        SIZE_8 = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK
    } rx_state_t;

    // Index of the last data bit: 5 bits -> 4, ..., 8 bits -> 7.
    function automatic logic [2:0] last_bit_index(input logic [1:0] size);
        return 3'(size) + 3'd4;
    endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
module rx_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s
);

    logic [1:0] sync_q;

    // NOTE: resets to 1 (line idle) so leaving reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];

endmodule

// File: rtl/receiver.sv
// UART receive engine: oversampled start detection, 5-8 data bits, optional
// parity, one or two stop bits, single-cycle write into the receive FIFO.
module receiver
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brgen,
    input  logic       enable,
    input  logic [1:0] size,
    input  logic [1:0] parity,
    input  logic       stop2,
    input  logic       rx_in,
    input  logic       full,
    output logic [8:0] wr_data,
    output logic       wr_request,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    logic            rx_s;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bitn_q;
    logic [7:0]      shift_q;
    logic            perr_q;
    logic [8:0]      wr_data_q;
    logic            wr_req_q;
    logic            ferr_q;
    logic            ovr_q;

    logic            half_tick;
    logic            full_tick;
    logic            parity_en;
    logic            perr_d;

    rx_synchronizer u_sync (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    assign half_tick = brgen && (cnt_q == HALF_M1);
    assign full_tick = brgen && (cnt_q == FULL_M1);
    assign parity_en = (parity == PAR_EVEN) || (parity == PAR_ODD);
    // Unused upper shift bits are cleared at frame start, so they do not disturb the XOR.
    assign perr_d    = ((^shift_q) ^ rx_s) != (parity == PAR_ODD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitn_q    <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            wr_data_q <= '0;
            wr_req_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            wr_req_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;

            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (brgen && !rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end

                    START: begin
                        if (half_tick) begin
                            if (!rx_s) begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                                bitn_q  <= '0;
                                shift_q <= '0;
                                perr_q  <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (brgen) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    DATA: begin
                        if (full_tick) begin
                            shift_q[bitn_q] <= rx_s;
                            cnt_q           <= '0;
                            if (bitn_q == last_bit_index(size)) begin
                                state_q <= parity_en ? PARITY : STOP1;
                            end else begin
                                bitn_q <= bitn_q + 3'd1;
                            end
                        end else if (brgen) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    PARITY: begin
                        if (full_tick) begin
                            perr_q  <= perr_d;
                            cnt_q   <= '0;
                            state_q <= STOP1;
                        end else if (brgen) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    STOP1, STOP2: begin
                        if (full_tick) begin
                            cnt_q <= '0;
                            if (!rx_s) begin
                                ferr_q  <= 1'b1;
                                state_q <= BRK;
                            end else if (state_q == STOP1 && stop2) begin
                                state_q <= STOP2;
                            end else begin
                                // Re-arm mid-way through the last stop bit.
                                if (!full) begin
                                    wr_req_q  <= 1'b1;
                                    wr_data_q <= {perr_q, shift_q};
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                                state_q <= IDLE;
                            end
                        end else if (brgen) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    BRK: begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_data       = wr_data_q;
    assign wr_request    = wr_req_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule
